// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// I2C target front end: decodes START/STOP, device address, register pointer and data, and issues register-bank strobes.
// Latency: 3 clk pin-to-decision (2-FF sync + edge register); sda_oe updates 3-4 clk after an SCL fall.
// Backpressure: none; SCL is never stretched, so the register file must accept reg_we and supply reg_rdata every cycle.
// Ports: clk/rst_n; scl_in/sda_in pin levels; sda_oe open-drain pull-down enable;
//        reg_addr/reg_wdata/reg_we write side, reg_rdata/reg_re read side; busy while addressed.
module i2c_target #(
   parameter logic [6:0]  DEV_ADDR = 7'h48,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   input  logic [7:0]        reg_rdata,
   output logic              reg_re,
   output logic              busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   // Synchronizers reset to the idle (pulled-up) bus level so reset release is not seen as an edge.
   logic scl_meta, scl_sync, scl_prev;
   logic sda_meta, sda_sync, sda_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_meta <= 1'b1; scl_sync <= 1'b1; scl_prev <= 1'b1;
         sda_meta <= 1'b1; sda_sync <= 1'b1; sda_prev <= 1'b1;
      end else begin
         scl_meta <= scl_in; scl_sync <= scl_meta; scl_prev <= scl_sync;
         sda_meta <= sda_in; sda_sync <= sda_meta; sda_prev <= sda_sync;
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_sync & ~scl_prev;
   assign scl_fall  = ~scl_sync & scl_prev;
   assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
   assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

   state_t            state, state_n;
   logic [3:0]        bit_cnt, bit_cnt_n;
   logic [7:0]        shreg, shreg_n;
   logic              rw, rw_n;
   logic              sda_oe_n, busy_n, reg_we_n, reg_re_n;
   logic [ADDR_W-1:0] reg_addr_n;
   logic [7:0]        reg_wdata_n;
   logic [7:0]        byte_in;

   assign byte_in = {shreg[6:0], sda_sync};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         rw        <= rw_n;
         sda_oe    <= sda_oe_n;
         busy      <= busy_n;
         reg_addr  <= reg_addr_n;
         reg_wdata <= reg_wdata_n;
         reg_we    <= reg_we_n;
         reg_re    <= reg_re_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      rw_n        = rw;
      sda_oe_n    = sda_oe;
      busy_n      = busy;
      reg_wdata_n = reg_wdata;
      reg_we_n    = 1'b0;
      reg_re_n    = 1'b0;
      // The pointer advances on the cycle after each write strobe.
      reg_addr_n  = reg_we ? (reg_addr + ADDR_ONE) : reg_addr;

      if (stop_det) begin
         state_n   = IDLE;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
         busy_n    = 1'b0;
      end else if (start_det) begin
         state_n   = ADDR;
         bit_cnt_n = '0;
         busy_n    = 1'b1;
      end else begin
         case (state)
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  shreg_n   = byte_in;
                  bit_cnt_n = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     if (state == ADDR) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                           state_n = ADDR_ACK;
                           rw_n    = byte_in[0];
                        end else begin
                           // Not ours: stay off the bus until the next START.
                           state_n   = IDLE;
                           bit_cnt_n = '0;
                           busy_n    = 1'b0;
                        end
                     end else if (state == PTR) begin
                        reg_addr_n = byte_in[ADDR_W-1:0];
                        state_n    = PTR_ACK;
                     end else begin
                        reg_we_n    = 1'b1;
                        reg_wdata_n = byte_in;
                        state_n     = WDATA_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               // bit_cnt==8: ACK not yet driven; bit_cnt==0: 9th SCL rise already seen.
               if (scl_fall && bit_cnt == 4'd8) begin
                  sda_oe_n = 1'b1;
               end else if (scl_rise) begin
                  bit_cnt_n = '0;
               end else if (scl_fall) begin
                  sda_oe_n = 1'b0;
                  if (state == ADDR_ACK && rw) begin
                     // The fall ending the ACK clock is also where the read MSB goes out.
                     reg_re_n = 1'b1;
                     shreg_n  = reg_rdata;
                     sda_oe_n = ~reg_rdata[7];
                     state_n  = RDATA;
                  end else if (state == ADDR_ACK) begin
                     state_n = PTR;
                  end else begin
                     state_n = WDATA;
                  end
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe_n  = 1'b0;
                     bit_cnt_n = '0;
                     state_n   = MACK;
                  end else begin
                     sda_oe_n = ~shreg[6];
                     shreg_n  = {shreg[6:0], 1'b0};
                  end
               end
            end
            MACK: begin
               // bit_cnt==1 marks a master ACK still waiting for the fall to load the next byte.
               if (scl_rise) begin
                  reg_addr_n = reg_addr + ADDR_ONE;
                  if (!sda_sync) begin
                     bit_cnt_n = 4'd1;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end
               end else if (scl_fall && bit_cnt == 4'd1) begin
                  reg_re_n  = 1'b1;
                  shreg_n   = reg_rdata;
                  sda_oe_n  = ~reg_rdata[7];
                  bit_cnt_n = '0;
                  state_n   = RDATA;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule
